arith_pipe: RTL and testbench

ARITH_PIPE -- requirements
Module: arith_pipe

---
 rtl/arith_pipe_if.sv | 44 ++++
 rtl/arith_pipe.sv | 142 ++++++++++++++
 tb/tb_arith_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_pipe_if.sv
// -----------------------------------------------------------------------------
// arith_pipe_if -- handshake bundle for the two-stage arithmetic pipeline.
//
// Signals (WIDTH = operand/result width):
//   ai, bi [WIDTH]  operands A and B
//   ci              carry-in (used by the add-with-carry operation only)
//   si [2]          operation select
//   in_valid        producer offers an input beat
//   in_ready        pipeline accepts the input beat this cycle
//   out [WIDTH]     result
//   carry           carry-out / no-borrow flag
//   Z, N, V         zero, negative and signed-overflow flags
//   out_valid       pipeline offers a result beat
//   out_ready       consumer accepts the result beat
//
// Modports: master = beat producer / result consumer, slave = the pipeline.
// -----------------------------------------------------------------------------
interface arith_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             ci;
    logic [1:0]       si;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             Z;
    logic             N;
    logic             V;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output ai, bi, ci, si, in_valid, out_ready,
        input  in_ready, out, carry, Z, N, V, out_valid
    );

    modport slave (
        input  ai, bi, ci, si, in_valid, out_ready,
        output in_ready, out, carry, Z, N, V, out_valid
    );
endinterface

// File: rtl/arith_pipe.sv
// -----------------------------------------------------------------------------
// arith_pipe -- two-stage valid/ready pipelined adder/subtractor with flags.
//
// Stage 1 registers the operands and select; stage 2 registers the result and
// the carry/Z/N/V flags. Each stage advances when the stage after it is empty
// or transferring, so the pipeline sustains one beat per cycle and stalls
// without losing or duplicating beats.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; empties the pipeline
//   bus    arith_pipe_if.slave (operands, select, flags, both handshakes)
//
// Operations (si): 00 A+B+ci, 01 A-B, 10 A+1, 11 A-1.
//
// Optional build macro ARITH_PIPE_SAT_EN: on signed overflow the result
// saturates to the signed max/min; carry and V still describe the raw sum,
// Z and N describe the saturated result. Without it the result wraps.
// -----------------------------------------------------------------------------
module arith_pipe #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    arith_pipe_if.slave  bus
);
    // Stage 1: captured operands.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_ci;
    logic [1:0]       s1_si;

    // Stage 2: registered result and flags.
    logic             s2_valid;
    logic [WIDTH-1:0] s2_out;
    logic             s2_carry;
    logic             s2_z;
    logic             s2_n;
    logic             s2_v;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    // Stage 2 may load when empty or when its result leaves this cycle; stage 1
    // moves forward only when it holds a beat and stage 2 can take it.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !s1_valid || s2_adv;
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Every operation is one (WIDTH+1)-bit add of A, an effective B and a
    // carry-in, so a single adder serves all four selects.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;
    logic             v_nxt;
    logic [WIDTH-1:0] res;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        b_eff = s1_b;
        c_eff = s1_ci;
        unique case (s1_si)
            2'b00: begin b_eff = s1_b;    c_eff = s1_ci; end
            2'b01: begin b_eff = ~s1_b;   c_eff = 1'b1;  end
            2'b10: begin b_eff = '0;      c_eff = 1'b1;  end
            2'b11: begin b_eff = '1;      c_eff = 1'b0;  end
            default: begin b_eff = s1_b;  c_eff = s1_ci; end
        endcase
    end

    assign sum   = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    // Overflow: both addends share a sign that the sum does not.
    assign v_nxt = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != s1_a[WIDTH-1]);

`ifdef ARITH_PIPE_SAT_EN
    // On overflow the true sum has the addends' sign: positive addends clamp
    // to the signed max, negative ones to the signed min.
    always_comb begin
        res = sum[WIDTH-1:0];
        if (v_nxt) begin
            res = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res = sum[WIDTH-1:0];
`endif

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values and stage order does not matter.
    // NOTE: the data registers are reset along with the valid bits because the
    // result and flags are visible outputs that must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ci    <= 1'b0;
            s1_si    <= 2'b00;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.ai;
            s1_b     <= bus.bi;
            s1_ci    <= bus.ci;
            s1_si    <= bus.si;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_carry <= 1'b0;
            s2_z     <= 1'b0;
            s2_n     <= 1'b0;
            s2_v     <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_out   <= res;
            s2_carry <= sum[WIDTH];
            s2_z     <= (res == '0);
            s2_n     <= res[WIDTH-1];
            s2_v     <= v_nxt;
        end else if (s2_valid && bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_out;
    assign bus.carry     = s2_carry;
    assign bus.Z         = s2_z;
    assign bus.N         = s2_n;
    assign bus.V         = s2_v;
endmodule

// File: tb/tb_arith_pipe.sv
// -----------------------------------------------------------------------------
// tb_arith_pipe -- directed self-checking bench for arith_pipe (WIDTH = 8).
// Expected results are hand-computed constants in the vector table; the
// wrap or saturate column is chosen by ARITH_PIPE_SAT_EN.
// -----------------------------------------------------------------------------
module tb_arith_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arith_pipe_if #(.WIDTH(W)) bus ();
    arith_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [1:0] si;
        logic [7:0] ow;   // wrapped result
        logic [7:0] os;   // saturated result
        logic       c;
        logic       v;
    } vec_t;

    vec_t tbl [12];

    task automatic init_table();
        tbl[0]  = '{8'hAA, 8'h55, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{8'hAA, 8'h55, 1'b0, 2'b01, 8'h55, 8'h80, 1'b1, 1'b1};
        tbl[2]  = '{8'h7F, 8'h99, 1'b0, 2'b10, 8'h80, 8'h7F, 1'b0, 1'b1};
        tbl[3]  = '{8'h00, 8'hC3, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 8'h7F, 1'b0, 1'b1};
        tbl[5]  = '{8'h80, 8'h80, 1'b0, 2'b00, 8'h00, 8'h80, 1'b1, 1'b1};
        tbl[6]  = '{8'h05, 8'h05, 1'b0, 2'b01, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{8'h03, 8'h05, 1'b0, 2'b01, 8'hFE, 8'hFE, 1'b0, 1'b0};
        tbl[8]  = '{8'h80, 8'h00, 1'b0, 2'b11, 8'h7F, 8'h80, 1'b1, 1'b1};
        tbl[9]  = '{8'hFF, 8'h00, 1'b0, 2'b10, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{8'h10, 8'h01, 1'b1, 2'b01, 8'h0F, 8'h0F, 1'b1, 1'b0};
        tbl[11] = '{8'h10, 8'h33, 1'b1, 2'b10, 8'h11, 8'h11, 1'b0, 1'b0};
    endtask

    // Expected {out, carry, Z, N, V} for table entry i.
    function automatic logic [11:0] exp_res(int i);
        logic [7:0] o;
`ifdef ARITH_PIPE_SAT_EN
        o = tbl[i].os;
`else
        o = tbl[i].ow;
`endif
        return {o, tbl[i].c, (o == 8'h00), o[7], tbl[i].v};
    endfunction

    function automatic logic [11:0] act_res();
        return {bus.out, bus.carry, bus.Z, bus.N, bus.V};
    endfunction

    task automatic drive_beat(int i);
        bus.ai       = tbl[i].a;
        bus.bi       = tbl[i].b;
        bus.ci       = tbl[i].ci;
        bus.si       = tbl[i].si;
        bus.in_valid = 1'b1;
    endtask

    // Garbage on the data lines while in_valid is low must not matter.
    task automatic idle_inputs();
        bus.ai       = 8'h5A;
        bus.bi       = 8'hC6;
        bus.ci       = 1'b1;
        bus.si       = 2'b01;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, act_res()} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", {bus.out_valid, act_res()}, 13'h0);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL post_reset_idle: got valid/ready %b expected 01", {bus.out_valid, bus.in_ready});
        end
    endtask

    // One beat at a time: check latency and every result/flag combination.
    task automatic test_ops();
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_beat(i);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL ops_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            @(posedge clk);
            #1;
            idle_inputs();
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!bus.out_valid && lat < 8);
            vectors++;
            if (lat != 2) begin
                miscompares++;
                $display("FAIL ops_latency[%0d]: got %0d expected 2", i, lat);
            end
            vectors++;
            if (act_res() !== exp_res(i)) begin
                miscompares++;
                $display("FAIL ops_result[%0d]: got %h expected %h", i, act_res(), exp_res(i));
            end
        end
    endtask

    // Four beats on consecutive cycles with the output always ready.
    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== (cyc >= 2 && cyc <= 5)) begin
                miscompares++;
                $display("FAIL b2b_out_valid[c%0d]: got %b expected %b", cyc, bus.out_valid, (cyc >= 2 && cyc <= 5));
            end
            if (bus.out_valid === 1'b1 && rx < 4) begin
                vectors++;
                if (act_res() !== exp_res(4 + rx)) begin
                    miscompares++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", rx, act_res(), exp_res(4 + rx));
                end
                rx++;
            end
            if (tx < 4) begin
                vectors++;
                if (bus.in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_in_ready[c%0d]: got %b expected 1", cyc, bus.in_ready);
                end
                drive_beat(4 + tx);
                tx++;
            end else begin
                idle_inputs();
            end
        end
        vectors++;
        if (rx != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d expected 4", rx);
        end
    endtask

    // out_ready low for cycles 2-5 while four beats are offered continuously.
    task automatic test_stall();
        int tx = 0;
        int rx = 0;
        int last_cyc = -1;
        for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 2 && cyc <= 5);
            #1;
            if (cyc == 2) begin
                vectors++;
                if (tx != 2 || bus.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_fill: got accepted=%0d in_ready=%b expected accepted=2 in_ready=0", tx, bus.in_ready);
                end
            end
            if (cyc >= 2 && cyc <= 5) begin
                vectors++;
                if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL stall_hs[c%0d]: got valid/ready %b expected 10", cyc, {bus.out_valid, bus.in_ready});
                end
            end
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (act_res() !== exp_res(8 + rx)) begin
                    miscompares++;
                    $display("FAIL stall_result[%0d c%0d]: got %h expected %h", rx, cyc, act_res(), exp_res(8 + rx));
                end
                if (bus.out_ready) begin
                    rx++;
                    last_cyc = cyc;
                end
            end
            if (tx < 4) begin
                drive_beat(8 + tx);
                if (bus.in_ready) tx++;
            end else begin
                idle_inputs();
            end
        end
        vectors++;
        if (rx != 4 || last_cyc != 9) begin
            miscompares++;
            $display("FAIL stall_count: got %0d beats last at c%0d expected 4 at c9", rx, last_cyc);
        end
        @(negedge clk);
        idle_inputs();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_no_dup: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    // Two beats in flight, then reset; nothing stale may emerge afterwards.
    task automatic test_reset_midflight();
        int lat;
        logic seen;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive_beat(1);
        @(negedge clk);
        drive_beat(2);
        @(negedge clk);
        idle_inputs();
        vectors++;
        if ({bus.out_valid, bus.in_ready, act_res()} !== {2'b10, exp_res(1)}) begin
            miscompares++;
            $display("FAIL midflight_loaded: got %h expected %h", {bus.out_valid, bus.in_ready, act_res()}, {2'b10, exp_res(1)});
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, act_res()} !== 13'h0) begin
            miscompares++;
            $display("FAIL midflight_reset_outputs: got %h expected %h", {bus.out_valid, act_res()}, 13'h0);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight_reset_in_ready: got %b expected 1", bus.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_stale: got stale out_valid expected none");
        end
        drive_beat(3);
        @(posedge clk);
        #1;
        idle_inputs();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 8);
        vectors++;
        if (lat != 2 || act_res() !== exp_res(3)) begin
            miscompares++;
            $display("FAIL midflight_first_beat: got lat=%0d res=%h expected lat=2 res=%h", lat, act_res(), exp_res(3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_table();
        test_reset();
        test_ops();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
